// File: rtl/fsm_count_driver.sv
// Serial-stream driver for a saturating 0..MAX_COUNT pulse counter: accepts a target
// count and emits the minimal 1/0 stream that moves the downstream counter onto it.
module fsm_count_driver #(
  parameter int MAX_COUNT = 8,
  parameter int W         = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt_value,
  output logic         ser_out,
  output logic [W-1:0] shadow,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [W-1:0] MAX = W'(MAX_COUNT);

  typedef enum logic [2:0] {IDLE, FILL, WRAP, LOAD, FIN} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] target, target_nxt;
  logic [W-1:0] shadow_nxt;
  logic         err_q, err_nxt;
  logic         ser_nxt;

  // Shadow follows the downstream counter from the bit currently on the wire.
  always_comb begin
    shadow_nxt = shadow;
    if (ser_out && shadow < MAX)
      shadow_nxt = shadow + 1'b1;
    else if (!ser_out && shadow == MAX)
      shadow_nxt = '0;
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    err_nxt    = err_q;
    unique case (state)
      IDLE: begin
        if (tgt_valid) begin
          target_nxt = tgt_value;
          err_nxt    = 1'b0;
          if (tgt_value > MAX) begin
            state_nxt = FIN;
            err_nxt   = 1'b1;
          end else if (tgt_value == shadow) begin
            state_nxt = FIN;
          end else if (tgt_value > shadow) begin
            state_nxt = LOAD;
          end else if (shadow < MAX) begin
            state_nxt = FILL;
          end else begin
            state_nxt = WRAP;
          end
        end
      end
      FILL: if (shadow_nxt == MAX) state_nxt = WRAP;
      WRAP: state_nxt = (target != '0) ? LOAD : FIN;
      LOAD: if (shadow_nxt == target) state_nxt = FIN;
      FIN: begin
        state_nxt = IDLE;
        err_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    // Serial bit is decoded from where the FSM is heading, so it lands one edge
    // ahead of the shadow update it causes. Outside a sequence, hold the counter.
    unique case (state_nxt)
      FILL, LOAD: ser_nxt = 1'b1;
      WRAP:       ser_nxt = 1'b0;
      default:    ser_nxt = (shadow_nxt == MAX);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      target  <= '0;
      err_q   <= 1'b0;
      shadow  <= '0;
      ser_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      err_q   <= err_nxt;
      shadow  <= shadow_nxt;
      ser_out <= ser_nxt;
    end
  end

  assign tgt_ready = (state == IDLE);
  assign busy      = (state == FILL) || (state == WRAP) || (state == LOAD);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && err_q;

endmodule

// File: tb/tb_fsm_count_driver.sv
// Directed bench for fsm_count_driver: a request table with hand-computed latency,
// serial bit counts and final shadow, plus saturation, reset and back-to-back sequences.
module tb_fsm_count_driver;

  localparam int MAXC = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] tgt_value;
  logic       ser_out;
  logic [3:0] shadow;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int model   = 0;

  fsm_count_driver #(.MAX_COUNT(MAXC), .W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_value(tgt_value),
    .ser_out(ser_out), .shadow(shadow),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream counter fed by ser_out, sharing clock and reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     model <= 0;
    else if (ser_out && model < MAXC) model <= model + 1;
    else if (!ser_out && model == MAXC) model <= 0;
  end

  always @(negedge clk) begin
    if (reset_n) check("shadow_vs_counter", int'(shadow), model);
  end

  typedef struct {
    logic [3:0] value;
    int         lat;
    int         ones;
    int         zeros;
    int         err;
    int         shadow;
  } vec_t;

  vec_t vecs[16];

  // One request: offer value, then measure cycles to done and serial bits seen.
  // keep leaves tgt_valid high afterwards with an illegal value that must be ignored.
  task automatic do_req(input logic [3:0] value, input bit keep, input int e_lat,
                        input int e_ones, input int e_zeros, input int e_err,
                        input int e_shadow);
    int lat, ones, zeros, err_seen, bad;
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    tgt_value = value;
    check("ready_before_req", int'(tgt_ready), 1);
    @(posedge clk); #1;
    tgt_valid = keep;
    if (keep) tgt_value = 4'hF;
    lat = 0; ones = 0; zeros = 0; err_seen = 0; bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat      = c;
        err_seen = int'(err);
        break;
      end
      if (ser_out) ones++; else zeros++;
      if (tgt_ready || err) bad++;
    end
    check($sformatf("latency_%0d", value), lat, e_lat);
    check($sformatf("ones_%0d", value), ones, e_ones);
    check($sformatf("zeros_%0d", value), zeros, e_zeros);
    check($sformatf("err_%0d", value), err_seen, e_err);
    check($sformatf("final_shadow_%0d", value), int'(shadow), e_shadow);
    check("ready_err_low_while_busy", bad, 0);
  endtask

  initial begin
    vecs[0]  = '{4'd5,  6, 5, 0, 0, 5};
    vecs[1]  = '{4'd6,  2, 1, 0, 0, 6};
    vecs[2]  = '{4'd2,  6, 4, 1, 0, 2};
    vecs[3]  = '{4'd3,  2, 1, 0, 0, 3};
    vecs[4]  = '{4'd8,  6, 5, 0, 0, 8};
    vecs[5]  = '{4'd0,  2, 0, 1, 0, 0};
    vecs[6]  = '{4'd4,  5, 4, 0, 0, 4};
    vecs[7]  = '{4'd4,  1, 0, 0, 0, 4};
    vecs[8]  = '{4'd12, 1, 0, 0, 1, 4};
    vecs[9]  = '{4'd8,  5, 4, 0, 0, 8};
    vecs[10] = '{4'd8,  1, 0, 0, 0, 8};
    vecs[11] = '{4'd15, 1, 0, 0, 1, 8};
    vecs[12] = '{4'd7,  9, 7, 1, 0, 7};
    vecs[13] = '{4'd6,  9, 7, 1, 0, 6};
    vecs[14] = '{4'd0,  4, 2, 1, 0, 0};
    vecs[15] = '{4'd9,  1, 0, 0, 1, 0};

    reset_n   = 1'b0;
    tgt_valid = 1'b0;
    tgt_value = '0;
    #3;
    check("rst_ready",  int'(tgt_ready), 1);
    check("rst_busy",   int'(busy),      0);
    check("rst_done",   int'(done),      0);
    check("rst_err",    int'(err),       0);
    check("rst_ser",    int'(ser_out),   0);
    check("rst_shadow", int'(shadow),    0);
    #19 reset_n = 1'b1;

    foreach (vecs[i])
      do_req(vecs[i].value, 1'b0, vecs[i].lat, vecs[i].ones, vecs[i].zeros,
             vecs[i].err, vecs[i].shadow);

    // Saturation: counter held at max through a long idle stretch, then wrapped to 0.
    do_req(4'd8, 1'b0, 9, 8, 0, 0, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold_ser", int'(ser_out), 1);
      check("idle_hold_shadow", int'(shadow), 8);
    end
    do_req(4'd0, 1'b0, 2, 0, 1, 0, 0);

    // Reset in the middle of a down sequence.
    do_req(4'd7, 1'b0, 8, 7, 0, 0, 7);
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    tgt_value = 4'd1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    check("busy_in_fill", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_ready",  int'(tgt_ready), 1);
    check("abort_busy",   int'(busy),      0);
    check("abort_done",   int'(done),      0);
    check("abort_ser",    int'(ser_out),   0);
    check("abort_shadow", int'(shadow),    0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_req(4'd3, 1'b0, 4, 3, 0, 0, 3);

    // Back-to-back with tgt_valid held high throughout.
    do_req(4'd2, 1'b1, 9, 7, 1, 0, 2);
    do_req(4'd7, 1'b1, 6, 5, 0, 0, 7);
    do_req(4'd1, 1'b0, 4, 2, 1, 0, 1);
    check("b2b_model", model, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
